ssd_scan: RTL

Receive-side driver for the board's 8-digit seven-segment display. Consumes the per-digit character stream (`display_char`, one-hot `ssd_en`, `shift_strobe`) produced by the writeback display sequencer. Assembles a full 32-bit frame in a shadow buffer, commits it atomically on `shift_strobe`, and time-multiplexes the committed frame onto active-low anode/cathode pins at a parameterised refresh rate.

---
 rtl/ssd_pkg.sv | 14 +
 rtl/ssd_hex7seg.sv | 13 +
 rtl/ssd_scan.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared constants and hex-to-segment table for the seven-segment scanner
package ssd_pkg;

    localparam int         NUM_DIGITS = 8;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [7:0] AN_OFF     = 8'hFF;

    // Active-low cathode patterns {g,f,e,d,c,b,a}, indexed by hex nibble 0..F.
    localparam logic [6:0] HEX7_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/ssd_hex7seg.sv
// rtl/ssd_hex7seg.sv - combinational hex nibble to active-low segment lookup
//   nibble : input  [3:0] hex value
//   seg    : output [6:0] cathodes {g,f,e,d,c,b,a}, active low
module ssd_hex7seg
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX7_TABLE[nibble];

endmodule

// File: rtl/ssd_scan.sv
// rtl/ssd_scan.sv - 8-digit seven-segment frame capture, atomic commit and multiplexed scan
//   Optional feature macro: SSD_BLANK_LEADING_ZEROS_EN (blank leading zero digits, digit 0 always lit)
//   clk, n_rst           : clock, asynchronous active-low reset
//   display_char[3:0]    : nibble for the digit selected by ssd_en
//   ssd_en[7:0]          : one-hot digit select, bit 7 = leftmost digit
//   shift_strobe         : end of frame, commits shadow (with same-cycle capture) to active
//   seg[6:0], dp, an[7:0]: active-low display pins
//   frame_valid          : a frame has been committed since reset
//   protocol_err         : one-cycle pulse after a multi-hot ssd_en
module ssd_scan
    import ssd_pkg::*;
#(
    parameter int CLK_DIV = 100000
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [3:0] display_char,
    input  logic [7:0] ssd_en,
    input  logic       shift_strobe,
    output logic [6:0] seg,
    output logic       dp,
    output logic [7:0] an,
    output logic       frame_valid,
    output logic       protocol_err
);

    localparam int PW = $clog2(CLK_DIV);

    logic [31:0]   shadow_q, shadow_d;
    logic [31:0]   active_q, active_d;
    logic [PW-1:0] prescale_q, prescale_d;
    logic [2:0]    digit_q, digit_d;
    logic          frame_valid_q, frame_valid_d;
    logic          protocol_err_q, protocol_err_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    logic          en_any;
    logic          en_onehot;
    logic          tick;
    logic [6:0]    seg_lookup;
    logic [7:0]    blank_mask;

    assign en_any    = (ssd_en != 8'h00);
    assign en_onehot = en_any && ((ssd_en & (ssd_en - 8'd1)) == 8'h00);
    assign tick      = (prescale_q == PW'(CLK_DIV - 1));

    ssd_hex7seg u_hex7seg (
        .nibble (active_q[{digit_q, 2'b00} +: 4]),
        .seg    (seg_lookup)
    );

`ifdef SSD_BLANK_LEADING_ZEROS_EN
    logic lead_zero;

    // Walk from the leftmost digit; a digit is blanked while every nibble
    // to its left (and itself) is zero. Digit 0 is never part of the walk.
    always_comb begin
        lead_zero  = 1'b1;
        blank_mask = 8'h00;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lead_zero     = lead_zero && (active_q[4*i +: 4] == 4'h0);
            blank_mask[i] = lead_zero;
        end
    end
`else
    assign blank_mask = 8'h00;
`endif

    always_comb begin
        shadow_d       = shadow_q;
        active_d       = active_q;
        frame_valid_d  = frame_valid_q;
        protocol_err_d = en_any && !en_onehot;
        prescale_d     = tick ? '0 : prescale_q + PW'(1);
        digit_d        = tick ? digit_q - 3'd1 : digit_q;
        an_d           = an_q;
        seg_d          = seg_q;

        if (en_onehot) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (ssd_en[i]) begin
                    shadow_d[4*i +: 4] = display_char;
                end
            end
        end

        // Commit takes the merged shadow so the strobe-cycle digit is included.
        if (shift_strobe) begin
            active_d      = shadow_d;
            frame_valid_d = 1'b1;
        end

        // Outputs only move on a digit tick, so a commit never tears a digit.
        if (tick) begin
            if (!frame_valid_q || blank_mask[digit_q]) begin
                an_d  = AN_OFF;
                seg_d = SEG_BLANK;
            end else begin
                an_d  = ~(8'b1 << digit_q);
                seg_d = seg_lookup;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shadow_q       <= '0;
            active_q       <= '0;
            prescale_q     <= '0;
            digit_q        <= 3'd7;
            frame_valid_q  <= 1'b0;
            protocol_err_q <= 1'b0;
            an_q           <= AN_OFF;
            seg_q          <= SEG_BLANK;
        end else begin
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            prescale_q     <= prescale_d;
            digit_q        <= digit_d;
            frame_valid_q  <= frame_valid_d;
            protocol_err_q <= protocol_err_d;
            an_q           <= an_d;
            seg_q          <= seg_d;
        end
    end

    assign an           = an_q;
    assign seg          = seg_q;
    assign dp           = 1'b1;
    assign frame_valid  = frame_valid_q;
    assign protocol_err = protocol_err_q;

endmodule
